// File: rtl/num_token_parser_if.sv
// Character-in / token-out port bundle for num_token_parser.
// The slave modport is the parser side; the master modport is the byte source and decoder side.
interface num_token_parser_if #(
    parameter int NUM_BITS = 16
);
    logic [7:0]          char_in;
    logic                char_valid;
    logic                char_ready;
    logic [NUM_BITS-1:0] num_out;
    logic [7:0]          term_out;
    logic                num_err;
    logic                num_valid;
    logic                num_ready;

    modport master (
        output char_in, char_valid, num_ready,
        input  char_ready, num_out, term_out, num_err, num_valid
    );

    modport slave (
        input  char_in, char_valid, num_ready,
        output char_ready, num_out, term_out, num_err, num_valid
    );
endinterface

// File: rtl/num_token_parser.sv
// Signed decimal token parser: one ASCII byte per handshake in, {value, terminator, error} out.
// Define PARSER_FRAC_EN to accept a '.' fraction, whose digits are discarded (truncation toward zero).
module num_token_parser #(
    parameter int NUM_BITS = 16,
    parameter int ACC_BITS = NUM_BITS + 4
) (
    input  logic              clk,
    input  logic              reset,
    num_token_parser_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SIGN   = 3'd1,
        ST_DIGITS = 3'd2,
        ST_DONE   = 3'd3
`ifdef PARSER_FRAC_EN
        , ST_FRAC = 3'd4
`endif
    } state_t;

    localparam logic [ACC_BITS-1:0] ONE_ACC   = {{(ACC_BITS-1){1'b0}}, 1'b1};
    localparam logic [ACC_BITS-1:0] NEG_LIMIT = ONE_ACC << (NUM_BITS - 1);
    localparam logic [ACC_BITS-1:0] POS_LIMIT = NEG_LIMIT - ONE_ACC;
    localparam logic [ACC_BITS-1:0] ACC_MAX   = {ACC_BITS{1'b1}};
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
`ifdef PARSER_FRAC_EN
    localparam logic [7:0] CH_DOT   = 8'h2E;
`endif

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // For '0'..'9' the low nibble already equals (c ^ 0x30).
    function automatic logic [ACC_BITS-1:0] digit_acc(input logic [3:0] nib);
        return {{(ACC_BITS-4){1'b0}}, nib};
    endfunction

    function automatic logic [ACC_BITS-1:0] mul10_add(input logic [ACC_BITS-1:0] acc,
                                                      input logic [3:0] nib);
        logic [ACC_BITS+3:0] w;
        w = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{ACC_BITS{1'b0}}, nib};
        if (w[ACC_BITS+3:ACC_BITS] != 4'b0000) begin
            return ACC_MAX;
        end else begin
            return w[ACC_BITS-1:0];
        end
    endfunction

    function automatic logic over_limit(input logic [ACC_BITS-1:0] acc, input logic neg);
        return acc > (neg ? NEG_LIMIT : POS_LIMIT);
    endfunction

    function automatic logic [NUM_BITS-1:0] to_num(input logic [NUM_BITS-1:0] a, input logic neg);
        return neg ? (~a + {{(NUM_BITS-1){1'b0}}, 1'b1}) : a;
    endfunction

    state_t              state_r, state_s;
    logic [ACC_BITS-1:0] acc_r, acc_s;
    logic                neg_r, neg_s;
    logic                ovf_r, ovf_s;
    logic [NUM_BITS-1:0] num_out_r, num_out_s;
    logic [7:0]          term_out_r, term_out_s;
    logic                num_err_r, num_err_s;
    logic                num_valid_r, num_valid_s;
    logic                char_ready_r, char_ready_s;
    logic                accept_s, digit_s, finish_s, bad_s;
`ifdef PARSER_FRAC_EN
    logic                any_digit_r, any_digit_s;
`endif

    // Next state, accumulator update and result capture for the character accepted this edge
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        neg_s      = neg_r;
        ovf_s      = ovf_r;
        num_out_s  = num_out_r;
        term_out_s = term_out_r;
        num_err_s  = num_err_r;
        finish_s   = 1'b0;
        bad_s      = 1'b0;
`ifdef PARSER_FRAC_EN
        any_digit_s = any_digit_r;
`endif
        accept_s = bus.char_valid && char_ready_r;
        digit_s  = is_digit(bus.char_in);

        case (state_r)
            ST_IDLE: begin
                if (!accept_s || (bus.char_in == CH_SPACE)) begin
                    state_s = ST_IDLE;
                end else if ((bus.char_in == CH_MINUS) || (bus.char_in == CH_PLUS)) begin
                    neg_s   = (bus.char_in == CH_MINUS);
                    state_s = ST_SIGN;
                end else if (digit_s) begin
                    acc_s   = digit_acc(bus.char_in[3:0]);
                    state_s = ST_DIGITS;
`ifdef PARSER_FRAC_EN
                    any_digit_s = 1'b1;
`endif
                end
`ifdef PARSER_FRAC_EN
                else if (bus.char_in == CH_DOT) begin
                    acc_s   = {ACC_BITS{1'b0}};
                    state_s = ST_FRAC;
                end
`endif
                else begin
                    finish_s = 1'b1;
                    bad_s    = 1'b1;
                end
            end
            ST_SIGN: begin
                if (!accept_s) begin
                    state_s = ST_SIGN;
                end else if (digit_s) begin
                    acc_s   = digit_acc(bus.char_in[3:0]);
                    state_s = ST_DIGITS;
`ifdef PARSER_FRAC_EN
                    any_digit_s = 1'b1;
`endif
                end
`ifdef PARSER_FRAC_EN
                else if (bus.char_in == CH_DOT) begin
                    acc_s   = {ACC_BITS{1'b0}};
                    state_s = ST_FRAC;
                end
`endif
                else begin
                    finish_s = 1'b1;
                    bad_s    = 1'b1;
                end
            end
            ST_DIGITS: begin
                if (!accept_s) begin
                    state_s = ST_DIGITS;
                end else if (digit_s) begin
                    acc_s = mul10_add(acc_r, bus.char_in[3:0]);
                end
`ifdef PARSER_FRAC_EN
                else if (bus.char_in == CH_DOT) begin
                    state_s = ST_FRAC;
                end
`endif
                else begin
                    finish_s = 1'b1;
                end
            end
`ifdef PARSER_FRAC_EN
            ST_FRAC: begin
                if (!accept_s) begin
                    state_s = ST_FRAC;
                end else if (digit_s) begin
                    any_digit_s = 1'b1;
                end else begin
                    finish_s = 1'b1;
                    bad_s    = !any_digit_r;
                end
            end
`endif
            ST_DONE: begin
                if (bus.num_ready) begin
                    state_s = ST_IDLE;
                    acc_s   = {ACC_BITS{1'b0}};
                    neg_s   = 1'b0;
                    ovf_s   = 1'b0;
`ifdef PARSER_FRAC_EN
                    any_digit_s = 1'b0;
`endif
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Sticky: once the magnitude passes the signed range it stays flagged until the handshake.
        ovf_s = ovf_s | over_limit(acc_s, neg_s);

        if (finish_s) begin
            state_s    = ST_DONE;
            term_out_s = bus.char_in;
            num_err_s  = bad_s | ovf_r;
            num_out_s  = (bad_s | ovf_r) ? {NUM_BITS{1'b0}} : to_num(acc_r[NUM_BITS-1:0], neg_r);
        end else begin
            num_err_s  = num_err_r;
        end

        num_valid_s  = (state_s == ST_DONE);
        char_ready_s = (state_s != ST_DONE);
    end

    // State, accumulator and registered outputs; reset wins on any edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            acc_r        <= {ACC_BITS{1'b0}};
            neg_r        <= 1'b0;
            ovf_r        <= 1'b0;
            num_out_r    <= {NUM_BITS{1'b0}};
            term_out_r   <= 8'h00;
            num_err_r    <= 1'b0;
            num_valid_r  <= 1'b0;
            char_ready_r <= 1'b1;
`ifdef PARSER_FRAC_EN
            any_digit_r  <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            acc_r        <= acc_s;
            neg_r        <= neg_s;
            ovf_r        <= ovf_s;
            num_out_r    <= num_out_s;
            term_out_r   <= term_out_s;
            num_err_r    <= num_err_s;
            num_valid_r  <= num_valid_s;
            char_ready_r <= char_ready_s;
`ifdef PARSER_FRAC_EN
            any_digit_r  <= any_digit_s;
`endif
        end
    end

    assign bus.char_ready = char_ready_r;
    assign bus.num_valid  = num_valid_r;
    assign bus.num_out    = num_out_r;
    assign bus.term_out   = term_out_r;
    assign bus.num_err    = num_err_r;

endmodule

// File: tb/tb_num_token_parser.sv
// Directed bench for num_token_parser (NUM_BITS=16); observed word is {num_valid, num_err, term_out, num_out}.
module tb_num_token_parser;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passed = 0;
    logic [25:0] got;
    logic [25:0] exp;

    num_token_parser_if #(.NUM_BITS(16)) bus ();

    num_token_parser #(.NUM_BITS(16), .ACC_BITS(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] snap();
        return {bus.num_valid, bus.num_err, bus.term_out, bus.num_out};
    endfunction

    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        while ((bus.char_ready !== 1'b1) && (n < 20)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            $display("FAIL char_ready_timeout got=%b exp=1", bus.char_ready);
        end
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
        end
    endtask

    task automatic handshake();
        bus.num_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.num_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({bus.char_ready, snap()} !== {1'b1, 26'd0})
            $display("FAIL reset_state got=%h exp=%h", {bus.char_ready, snap()}, {1'b1, 26'd0});
        else passed++;
    endtask

    task automatic test_basic();
        bus.num_ready = 1'b1;
        send_str("123 ");
        checks++;
        exp = {1'b1, 1'b0, 8'h20, 16'd123};
        if ({bus.char_ready, snap()} !== {1'b0, exp})
            $display("FAIL basic_123 got=%h exp=%h", {bus.char_ready, snap()}, {1'b0, exp});
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.num_valid, bus.char_ready} !== 2'b01)
            $display("FAIL basic_release got=%b exp=01", {bus.num_valid, bus.char_ready});
        else passed++;
        bus.num_ready = 1'b0;
    endtask

    task automatic test_hold();
        send_str("  -45X");
        exp = {1'b1, 1'b0, 8'h58, 16'hFFD3};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.char_ready, snap()} !== {1'b0, exp})
                $display("FAIL hold_cycle%0d got=%h exp=%h", i, {bus.char_ready, snap()}, {1'b0, exp});
            else passed++;
            if (i < 4) begin
                @(posedge clk);
                #1;
            end
        end
        handshake();
        checks++;
        if ({bus.num_valid, bus.char_ready} !== 2'b01)
            $display("FAIL hold_idle got=%b exp=01", {bus.num_valid, bus.char_ready});
        else passed++;
    endtask

    task automatic test_boundaries();
        string       s[6] = '{"32767 ", "-32768 ", "32768 ", "9999999999 ", "007 ", "-0 "};
        logic [25:0] e[6] = '{{1'b1, 1'b0, 8'h20, 16'h7FFF},
                              {1'b1, 1'b0, 8'h20, 16'h8000},
                              {1'b1, 1'b1, 8'h20, 16'h0000},
                              {1'b1, 1'b1, 8'h20, 16'h0000},
                              {1'b1, 1'b0, 8'h20, 16'h0007},
                              {1'b1, 1'b0, 8'h20, 16'h0000}};
        for (int i = 0; i < 6; i++) begin
            send_str(s[i]);
            got = snap();
            checks++;
            if (got !== e[i]) $display("FAIL bound_%s got=%h exp=%h", s[i], got, e[i]);
            else passed++;
            handshake();
        end
    endtask

    task automatic test_errors();
        string       s[4] = '{"-G", "X", "+-", "1 "};
        logic [25:0] e[4] = '{{1'b1, 1'b1, 8'h47, 16'h0000},
                              {1'b1, 1'b1, 8'h58, 16'h0000},
                              {1'b1, 1'b1, 8'h2D, 16'h0000},
                              {1'b1, 1'b0, 8'h20, 16'h0001}};
        for (int i = 0; i < 4; i++) begin
            send_str(s[i]);
            got = snap();
            checks++;
            if (got !== e[i]) $display("FAIL err_%s got=%h exp=%h", s[i], got, e[i]);
            else passed++;
            handshake();
        end
    endtask

    task automatic test_dot();
`ifdef PARSER_FRAC_EN
        string       s[3] = '{"-3.75 ", ". ", "12.5."};
        logic [25:0] e[3] = '{{1'b1, 1'b0, 8'h20, 16'hFFFD},
                              {1'b1, 1'b1, 8'h20, 16'h0000},
                              {1'b1, 1'b0, 8'h2E, 16'h000C}};
`else
        string       s[3] = '{"12.", "5 ", "."};
        logic [25:0] e[3] = '{{1'b1, 1'b0, 8'h2E, 16'h000C},
                              {1'b1, 1'b0, 8'h20, 16'h0005},
                              {1'b1, 1'b1, 8'h2E, 16'h0000}};
`endif
        for (int i = 0; i < 3; i++) begin
            send_str(s[i]);
            got = snap();
            checks++;
            if (got !== e[i]) $display("FAIL dot_%0d got=%h exp=%h", i, got, e[i]);
            else passed++;
            handshake();
        end
    endtask

    task automatic test_reset_mid();
        send_str("98");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({bus.char_ready, bus.num_valid} !== 2'b10)
            $display("FAIL midreset_state got=%b exp=10", {bus.char_ready, bus.num_valid});
        else passed++;
        send_str("7\n");
        got = snap();
        exp = {1'b1, 1'b0, 8'h0A, 16'd7};
        checks++;
        if (got !== exp) $display("FAIL midreset_token got=%h exp=%h", got, exp);
        else passed++;
        handshake();
        send_str("5 ");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({bus.char_ready, snap()} !== {1'b1, 26'd0})
            $display("FAIL donereset got=%h exp=%h", {bus.char_ready, snap()}, {1'b1, 26'd0});
        else passed++;
    endtask

    task automatic test_back_to_back();
        bus.num_ready = 1'b1;
        send_str("1 ");
        got = snap();
        exp = {1'b1, 1'b0, 8'h20, 16'd1};
        checks++;
        if (got !== exp) $display("FAIL b2b_first got=%h exp=%h", got, exp);
        else passed++;
        send_str("-2;");
        got = snap();
        exp = {1'b1, 1'b0, 8'h3B, 16'hFFFE};
        checks++;
        if (got !== exp) $display("FAIL b2b_second got=%h exp=%h", got, exp);
        else passed++;
        @(posedge clk);
        #1;
        bus.num_ready = 1'b0;
    endtask

    initial begin
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        bus.num_ready  = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_boundaries();
        test_errors();
        test_dot();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
